// File: rtl/axis_quadrature_counter.sv
// Schmitt-trigger quadrature decoder: {B,A} ADC samples in, signed fringe position out on AXIS.
// Two pipeline stages (levels, then decode/position) advance on one output-driven enable.
`timescale 1ns / 1ps
module axis_quadrature_counter #(
   parameter int unsigned AXIS_TDATA_WIDTH = 32,
   parameter int unsigned POSITION_WIDTH   = 32
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [AXIS_TDATA_WIDTH/2-1:0] lower_threshold,
   input  logic [AXIS_TDATA_WIDTH/2-1:0] upper_threshold,
   input  logic                          position_clear,
   output logic [15:0]                   error_count,
   input  logic                          S_AXIS_tvalid,
   input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
   output logic                          S_AXIS_tready,
   output logic                          M_AXIS_tvalid,
   output logic [POSITION_WIDTH-1:0]     M_AXIS_tdata,
   input  logic                          M_AXIS_tready
);
   localparam int unsigned HalfW = AXIS_TDATA_WIDTH / 2;

   logic                      en, accept, thr_ok;
   logic signed [HalfW-1:0]   samp_a, samp_b, thr_lo, thr_hi;
   logic                      lvl_a_q, lvl_a_d, lvl_b_q, lvl_b_d;
   logic                      s1_valid_q, s1_thr_ok_q;
   logic [1:0]                cur, prev_q, prev_d;
   logic                      primed_q, primed_d;
   logic [15:0]               err_q, err_d;
   logic [POSITION_WIDTH-1:0] pos_q, pos_d, pos_upd;
   logic                      m_valid_q;
   logic [POSITION_WIDTH-1:0] m_data_q, m_data_d;

   assign en            = ~m_valid_q | M_AXIS_tready;
   assign S_AXIS_tready = en & ~areset;
   assign accept        = S_AXIS_tvalid & S_AXIS_tready;
   assign samp_a        = S_AXIS_tdata[HalfW-1:0];
   assign samp_b        = S_AXIS_tdata[2*HalfW-1:HalfW];
   assign thr_lo        = lower_threshold;
   assign thr_hi        = upper_threshold;
   assign thr_ok        = thr_lo < thr_hi;
   assign cur           = {lvl_b_q, lvl_a_q};

   assign M_AXIS_tvalid = m_valid_q;
   assign M_AXIS_tdata  = m_data_q;
   assign error_count   = err_q;

   // Stage 1: hysteresis on each channel; levels hold on invalid thresholds.
   always_comb begin
      lvl_a_d = lvl_a_q;
      lvl_b_d = lvl_b_q;
      if (accept && thr_ok) begin
         if (samp_a > thr_hi) begin
            lvl_a_d = 1'b1;
         end else if (samp_a < thr_lo) begin
            lvl_a_d = 1'b0;
         end
         if (samp_b > thr_hi) begin
            lvl_b_d = 1'b1;
         end else if (samp_b < thr_lo) begin
            lvl_b_d = 1'b0;
         end
      end
   end

   // Stage 2: quadrature decode into position and the output register.
   always_comb begin
      prev_d   = prev_q;
      primed_d = primed_q;
      err_d    = err_q;
      pos_upd  = pos_q;
      if (en && s1_valid_q) begin
         if (!s1_thr_ok_q) begin
            primed_d = 1'b0;
         end else if (!primed_q) begin
            prev_d   = cur;
            primed_d = 1'b1;
         end else begin
            prev_d = cur;
            unique case ({prev_q, cur})
               4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: pos_upd = pos_q + POSITION_WIDTH'(1);
               4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: pos_upd = pos_q - POSITION_WIDTH'(1);
               4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
                  if (err_q != 16'hFFFF) begin
                     err_d = err_q + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
      // Clear wins over a same-cycle count and ignores stall.
      pos_d    = position_clear ? '0 : pos_upd;
      m_data_d = m_data_q;
      if (en && s1_valid_q) begin
         m_data_d = pos_d;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         lvl_a_q     <= 1'b0;
         lvl_b_q     <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_thr_ok_q <= 1'b0;
         prev_q      <= 2'b00;
         primed_q    <= 1'b0;
         err_q       <= 16'd0;
         pos_q       <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
      end else begin
         pos_q <= pos_d;
         if (en) begin
            lvl_a_q     <= lvl_a_d;
            lvl_b_q     <= lvl_b_d;
            s1_valid_q  <= accept;
            s1_thr_ok_q <= thr_ok;
            prev_q      <= prev_d;
            primed_q    <= primed_d;
            err_q       <= err_d;
            m_valid_q   <= s1_valid_q;
            m_data_q    <= m_data_d;
         end
      end
   end

endmodule
